sysbus_arbiter: RTL and testbench
=================================

Name: sysbus_arbiter

Overview:
- Two-master arbiter sharing the single Sysbus between the core's instruction-fetch requester (m0) and data-memory requester (m1).
- Grants one owner per whole transaction: request phase, then a write-data phase or read-response burst.
- Routes bus handshakes and data only to the owner.
- Round-robin fairness. Sits between the Core front-end/LSU and the Sysbus port.

Parameters:
- DATA_W, 64, width of req/resp data
- TAG_W, 13, width of reqtag; bit TAG_W-1 is 1 for READ, 0 for WRITE
- BEATS, 8, beats per transaction (64-byte line / 8 bytes)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_reqcyc / m1_reqcyc  in  1  master request valid
- m0_req / m1_req  in  DATA_W  address (request phase) or write data (write phase)
- m0_reqtag / m1_reqtag  in  TAG_W  request tag
- m0_reqack / m1_reqack  out  1  request/write-beat accepted
- m0_respcyc / m1_respcyc  out  1  response beat valid
- m0_resp / m1_resp  out  DATA_W  response data
- m0_respack / m1_respack  in  1  master accepts response beat
- bus_reqcyc  out  1  Sysbus request valid
- bus_req  out  DATA_W  Sysbus request data
- bus_reqtag  out  TAG_W  Sysbus tag
- bus_reqack  in  1  Sysbus accepted request/beat
- bus_respcyc  in  1  Sysbus response beat valid
- bus_resp  in  DATA_W  Sysbus response data
- bus_respack  out  1  ack to Sysbus response
- owner  out  1  current/last granted master
- busy  out  1  state != IDLE
- err  out  1  sticky: response beat arrived with no read in progress

Behaviour:
- Reset (sync, active-high, wins over all other events, including mid-transaction): state=IDLE, beat_cnt=0, last=1 (so m0 wins first tie), owner=0, err=0. All ack/cyc outputs are 0 in the reset cycle and in the cycle after.
- States are IDLE, REQ, WDATA and RESP. All outputs not listed below are 0; m*_resp is always bus_resp.
- IDLE:
  - If any m*_reqcyc is high at edge N, register the winner as owner. On a tie, choose !last. Set last=winner and go to REQ at N+1.
  - No bus activity while in IDLE.
- REQ:
  - bus_reqcyc/req/reqtag = owner's signals, combinationally.
  - owner_reqack = bus_reqack in the same cycle.
  - On bus_reqack, capture tag bit TAG_W-1. Next state is RESP if it is 1, WDATA if it is 0. beat_cnt=0.
  - The owner must hold reqcyc/req/reqtag stable until acked. If the owner drops reqcyc before ack, return to IDLE (abandoned request).
- WDATA:
  - Owner's reqcyc/req/reqtag are passed to the bus; owner_reqack = bus_reqack.
  - A beat counts when bus_reqcyc && bus_reqack.
  - After BEATS beats, go to IDLE next cycle.
- RESP:
  - owner_respcyc = bus_respcyc; bus_respack = owner_respack.
  - A beat counts when bus_respcyc && bus_respack.
  - On the BEATS-th beat, go to IDLE next cycle.
  - A beat that is not acked is held by the bus and is not counted.
- beat_cnt is $clog2(BEATS)+1 bits and resets to 0 on each IDLE exit. No wrap: the transaction ends at beat_cnt==BEATS-1 plus a counted beat.
- bus_respcyc in IDLE, REQ or WDATA: bus_respack=0, err<=1 (sticky until reset), state unchanged.
- A non-owner never sees reqack or respcyc. Its request waits; it is served at the earliest one cycle after the owner's transaction ends (IDLE visit of one cycle).
- Latency: request seen at N gives bus_reqcyc at N+1 at best. Back-to-back transactions are separated by one IDLE cycle.
- busy = (state != IDLE). owner is stable during a transaction.

Test Plan:
- m0 read alone: m0_reqcyc=1, tag MSB=1, addr 0x1000 at cycle 1; bus_reqack at cycle 3 -> bus_reqcyc=1, bus_req=0x1000 in cycles 2-3; m0_reqack=1 in cycle 3 only; 8 resp beats 0x11..0x88 each seen on m0_resp with m0_respcyc=1; busy falls after the 8th beat; m1_respcyc stays 0.
- Simultaneous requests after reset: m0 and m1 assert in the same cycle -> m0 granted first (owner=0); m1 is granted one cycle after m0's 8th beat (owner=1). Next tie -> m0 wins.
- m1 write: tag MSB=0, addr 0x2000, then 8 data beats with bus_reqack stalling on beats 2 and 5 -> exactly 8 beats forwarded in order; no response routed; returns to IDLE.
- Response backpressure: m0_respack=0 for 3 cycles on beat 4 -> bus_respack=0 those cycles; beat_cnt holds; 8 beats still delivered in total.
- Stray response: bus_respcyc=1 while IDLE -> bus_respack=0, err=1 and holds until reset.
- Reset mid-RESP after beat 3: reset=1 for one cycle -> next cycle state IDLE, busy=0, err=0, all acks 0; a new m1 request is granted normally.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// Two-master Sysbus arbiter: round-robin grant held for a whole transaction (request + write burst or read burst).
// Latency: request seen at edge N drives bus_reqcyc from N+1; one IDLE cycle separates back-to-back transactions.
// Backpressure: bus_reqack/owner respack are forwarded combinationally; unacked beats are held and not counted.
module sysbus_arbiter #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13,
    parameter int BEATS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_reqcyc,
    input  logic [DATA_W-1:0] m0_req,
    input  logic [TAG_W-1:0]  m0_reqtag,
    output logic              m0_reqack,
    output logic              m0_respcyc,
    output logic [DATA_W-1:0] m0_resp,
    input  logic              m0_respack,
    input  logic              m1_reqcyc,
    input  logic [DATA_W-1:0] m1_req,
    input  logic [TAG_W-1:0]  m1_reqtag,
    output logic              m1_reqack,
    output logic              m1_respcyc,
    output logic [DATA_W-1:0] m1_resp,
    input  logic              m1_respack,
    output logic              bus_reqcyc,
    output logic [DATA_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [DATA_W-1:0] bus_resp,
    output logic              bus_respack,
    output logic              owner,
    output logic              busy,
    output logic              err
);
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic             last;
    logic             owner_q;
    logic             err_q;

    logic              own_reqcyc;
    logic [DATA_W-1:0] own_req;
    logic [TAG_W-1:0]  own_reqtag;
    logic              own_respack;
    logic              winner;
    logic              in_req;
    logic              in_resp;

    always_comb begin
        own_reqcyc  = owner_q ? m1_reqcyc  : m0_reqcyc;
        own_req     = owner_q ? m1_req     : m0_req;
        own_reqtag  = owner_q ? m1_reqtag  : m0_reqtag;
        own_respack = owner_q ? m1_respack : m0_respack;
        // Tie goes to whoever did not win last time; otherwise the lone requester.
        winner      = (m0_reqcyc && m1_reqcyc) ? !last : m1_reqcyc;
        // Reset masks every handshake output in the same cycle, even mid-transaction.
        in_req      = !reset && (state == REQ || state == WDATA);
        in_resp     = !reset && (state == RESP);
    end

    always_comb begin
        bus_reqcyc  = in_req && own_reqcyc;
        bus_req     = in_req ? own_req : '0;
        bus_reqtag  = in_req ? own_reqtag : '0;
        m0_reqack   = in_req && !owner_q && bus_reqack;
        m1_reqack   = in_req && owner_q && bus_reqack;
        m0_respcyc  = in_resp && !owner_q && bus_respcyc;
        m1_respcyc  = in_resp && owner_q && bus_respcyc;
        bus_respack = in_resp && own_respack;
        m0_resp     = bus_resp;
        m1_resp     = bus_resp;
        owner       = owner_q;
        busy        = (state != IDLE);
        err         = err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            last     <= 1'b1;
            owner_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // A response beat outside a read burst has no destination.
            if (bus_respcyc && state != RESP)
                err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (m0_reqcyc || m1_reqcyc) begin
                        owner_q  <= winner;
                        last     <= winner;
                        beat_cnt <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (!own_reqcyc) begin
                        state <= IDLE;
                    end else if (bus_reqack) begin
                        beat_cnt <= '0;
                        state    <= own_reqtag[TAG_W-1] ? RESP : WDATA;
                    end
                end
                WDATA: begin
                    if (own_reqcyc && bus_reqack) begin
                        if (beat_cnt == LAST_BEAT)
                            state <= IDLE;
                        else
                            beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus_respcyc && own_respack) begin
                        if (beat_cnt == LAST_BEAT)
                            state <= IDLE;
                        else
                            beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: table of per-cycle vectors for an m0 read with backpressure and a stray
// response, then hand-written sequences for arbitration, write stalls and reset mid-burst.
module tb_sysbus_arbiter;
    localparam int DW = 64;
    localparam int TW = 13;

    // Flag vector order: {bus_reqcyc, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc, bus_respack, owner, busy, err}
    localparam logic [8:0] E_BRC = 9'b1_0000_0000;
    localparam logic [8:0] E_R0  = 9'b0_0010_0000;
    localparam logic [8:0] E_A0  = 9'b0_1000_0000;
    localparam logic [8:0] E_BRA = 9'b0_0000_1000;
    localparam logic [8:0] E_BSY = 9'b0_0000_0010;
    localparam logic [8:0] E_ERR = 9'b0_0000_0001;

    logic clk = 1'b0;
    logic reset;
    logic m0_reqcyc, m1_reqcyc, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc, m0_respack, m1_respack;
    logic [DW-1:0] m0_req, m1_req, m0_resp, m1_resp, bus_req, bus_resp;
    logic [TW-1:0] m0_reqtag, m1_reqtag, bus_reqtag;
    logic bus_reqcyc, bus_reqack, bus_respcyc, bus_respack, owner, busy, err;

    always #5 clk = ~clk;

    sysbus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_reqcyc(m0_reqcyc), .m0_req(m0_req), .m0_reqtag(m0_reqtag), .m0_reqack(m0_reqack),
        .m0_respcyc(m0_respcyc), .m0_resp(m0_resp), .m0_respack(m0_respack),
        .m1_reqcyc(m1_reqcyc), .m1_req(m1_req), .m1_reqtag(m1_reqtag), .m1_reqack(m1_reqack),
        .m1_respcyc(m1_respcyc), .m1_resp(m1_resp), .m1_respack(m1_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_respack(bus_respack),
        .owner(owner), .busy(busy), .err(err)
    );

    typedef struct {
        logic          rst, c0, back, rcyc, ra0;
        logic [DW-1:0] d0, rdat;
        logic [8:0]    exp;
        logic [DW-1:0] ereq;
    } vec_t;

    vec_t          tbl[$];
    logic [DW-1:0] q0[$], q1[$], qb[$];
    int            checks = 0;
    int            errors = 0;

    function automatic logic [TW-1:0] tagv(input bit rd);
        return {rd, 12'h0A5};
    endfunction

    function automatic vec_t mk(input logic rst, input logic c0, input logic [DW-1:0] d0, input logic back,
                                input logic rcyc, input logic [DW-1:0] rdat, input logic ra0,
                                input logic [8:0] exp, input logic [DW-1:0] ereq);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.d0 = d0; v.back = back; v.rcyc = rcyc;
        v.rdat = rdat; v.ra0 = ra0; v.exp = exp; v.ereq = ereq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every transferred beat must match the oldest expected entry for its path.
    task automatic monitor();
        logic [DW-1:0] e;
        if (m0_respcyc && m0_respack) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL m0_resp: unexpected beat %0h", m0_resp);
            end else begin
                e = q0.pop_front();
                chk("m0_resp", m0_resp, e);
            end
        end
        if (m1_respcyc && m1_respack) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL m1_resp: unexpected beat %0h", m1_resp);
            end else begin
                e = q1.pop_front();
                chk("m1_resp", m1_resp, e);
            end
        end
        if (bus_reqcyc && bus_reqack) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL bus_req: unexpected beat %0h", bus_req);
            end else begin
                e = qb.pop_front();
                chk("bus_req beat", bus_req, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        m0_reqcyc = 0; m0_req = '0; m0_reqtag = '0; m0_respack = 0;
        m1_reqcyc = 0; m1_req = '0; m1_reqtag = '0; m1_respack = 0;
        bus_reqack = 0; bus_respcyc = 0; bus_resp = '0;
    endtask

    task automatic mreq(input bit m, input bit cyc, input bit rd, input logic [DW-1:0] d);
        if (m) begin
            m1_reqcyc = cyc; m1_req = d; m1_reqtag = tagv(rd);
        end else begin
            m0_reqcyc = cyc; m0_req = d; m0_reqtag = tagv(rd);
        end
    endtask

    task automatic resp_beats(input int n, input bit to_m1, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            bus_respcyc = 1; bus_resp = base + DW'(i);
            m0_respack = 1; m1_respack = 1;
            if (to_m1) q1.push_back(base + DW'(i));
            else       q0.push_back(base + DW'(i));
            #2;
            chk("busy in burst", busy, 1);
            tick();
        end
        bus_respcyc = 0; m0_respack = 0; m1_respack = 0;
    endtask

    initial begin
        logic [8:0] flags;
        clear_in();
        reset = 1;
        tick();

        // m0 read at 0x1000, ack on its second REQ cycle, 8 beats with a 3-cycle stall on beat 4.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9'h0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 9'h0, 0));
        tbl.push_back(mk(0, 1, 64'h1000, 0, 0, 0, 0, 9'h0, 0));
        tbl.push_back(mk(0, 1, 64'h1000, 0, 0, 0, 0, E_BRC | E_BSY, 64'h1000));
        tbl.push_back(mk(0, 1, 64'h1000, 1, 0, 0, 0, E_BRC | E_A0 | E_BSY, 64'h1000));
        for (int b = 1; b <= 8; b++) begin
            if (b == 4)
                repeat (3) tbl.push_back(mk(0, 0, 0, 0, 1, 64'h44, 0, E_R0 | E_BSY, 0));
            tbl.push_back(mk(0, 0, 0, 0, 1, 64'(b) * 64'h11, 1, E_R0 | E_BRA | E_BSY, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 9'h0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 64'hee, 1, 9'h0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_ERR, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_ERR, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, E_ERR, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 9'h0, 0));

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            m0_reqcyc = tbl[i].c0; m0_req = tbl[i].d0; m0_reqtag = tagv(1);
            bus_reqack = tbl[i].back; bus_respcyc = tbl[i].rcyc; bus_resp = tbl[i].rdat;
            m0_respack = tbl[i].ra0; m1_respack = 1;
            if (tbl[i].rcyc && (tbl[i].exp & E_BRA) != 0) q0.push_back(tbl[i].rdat);
            if (tbl[i].back && (tbl[i].exp & E_BRC) != 0) qb.push_back(tbl[i].ereq);
            #2;
            flags = {bus_reqcyc, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc, bus_respack, owner, busy, err};
            chk($sformatf("vec%0d flags", i), flags, tbl[i].exp);
            if ((tbl[i].exp & E_BRC) != 0) chk($sformatf("vec%0d bus_req", i), bus_req, tbl[i].ereq);
            tick();
        end
        reset = 0;
        clear_in();

        // Tie right after reset: m0 first, m1 one IDLE cycle after m0's last beat.
        reset = 1; tick(); reset = 0;
        #2;
        chk("post-reset owner", owner, 0);
        chk("post-reset err", err, 0);
        mreq(0, 1, 1, 64'hA000);
        mreq(1, 1, 1, 64'hB000);
        tick();
        #2;
        chk("tie1 owner", owner, 0);
        chk("tie1 bus_req", bus_req, 64'hA000);
        chk("tie1 bus_reqtag", bus_reqtag, tagv(1));
        bus_reqack = 1; qb.push_back(64'hA000);
        #1;
        chk("tie1 m0_reqack", m0_reqack, 1);
        chk("tie1 m1_reqack", m1_reqack, 0);
        tick();
        bus_reqack = 0; m0_reqcyc = 0;
        resp_beats(8, 0, 64'h100);
        #2;
        chk("gap cycle busy", busy, 0);
        tick();
        #2;
        chk("m1 granted owner", owner, 1);
        chk("m1 bus_req", bus_req, 64'hB000);
        bus_reqack = 1; qb.push_back(64'hB000);
        tick();
        bus_reqack = 0; m1_reqcyc = 0;
        resp_beats(8, 1, 64'h200);

        // Second tie goes to m0; m0 then abandons before ack and m1 is served.
        mreq(0, 1, 1, 64'hC000);
        mreq(1, 1, 1, 64'hC100);
        tick();
        #2;
        chk("tie2 owner", owner, 0);
        m0_reqcyc = 0;
        tick();
        #2;
        chk("abandon busy", busy, 0);
        tick();
        #2;
        chk("after abandon owner", owner, 1);
        m1_reqcyc = 0;
        tick();
        clear_in();

        // m1 write at 0x2000 with bus stalls on data beats 2 and 5.
        mreq(1, 1, 0, 64'h2000);
        tick();
        #2;
        chk("wr owner", owner, 1);
        chk("wr bus_reqtag", bus_reqtag, tagv(0));
        bus_reqack = 1; qb.push_back(64'h2000);
        tick();
        for (int k = 0; k < 8; k++) begin
            m1_req = 64'hD0 + DW'(k);
            if (k == 1 || k == 4) begin
                bus_reqack = 0;
                #2;
                chk("wr stall m1_reqack", m1_reqack, 0);
                tick();
            end
            bus_reqack = 1; qb.push_back(64'hD0 + DW'(k));
            #2;
            chk("wr m1_reqack", m1_reqack, 1);
            chk("wr busy", busy, 1);
            tick();
        end
        clear_in();
        #2;
        chk("wr done busy", busy, 0);
        chk("wr done err", err, 0);
        tick();

        // Stray beat during REQ, then reset after beat 3 of the read.
        mreq(0, 1, 1, 64'h3000);
        tick();
        bus_reqack = 1; qb.push_back(64'h3000);
        bus_respcyc = 1; bus_resp = 64'hbad; m0_respack = 1;
        #2;
        chk("stray in REQ bus_respack", bus_respack, 0);
        chk("stray in REQ m0_respcyc", m0_respcyc, 0);
        tick();
        clear_in();
        #2;
        chk("stray sets err", err, 1);
        resp_beats(3, 0, 64'h300);
        reset = 1; bus_respcyc = 1; bus_resp = 64'h303; m0_respack = 1;
        #2;
        chk("reset cycle bus_respack", bus_respack, 0);
        chk("reset cycle m0_respcyc", m0_respcyc, 0);
        tick();
        reset = 0; clear_in();
        mreq(1, 1, 1, 64'h4000);
        #2;
        chk("after reset busy", busy, 0);
        chk("after reset err", err, 0);
        chk("after reset bus_reqcyc", bus_reqcyc, 0);
        tick();
        #2;
        chk("new m1 owner", owner, 1);
        chk("new m1 bus_req", bus_req, 64'h4000);
        bus_reqack = 1; qb.push_back(64'h4000);
        tick();
        bus_reqack = 0; m1_reqcyc = 0;
        resp_beats(8, 1, 64'h400);
        #2;
        chk("final busy", busy, 0);
        tick();

        chk("m0 beats outstanding", DW'(q0.size()), 0);
        chk("m1 beats outstanding", DW'(q1.size()), 0);
        chk("bus beats outstanding", DW'(qb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
